// File: rtl/axi_slave_mem.sv
// AXI4 memory-mapped slave terminating bursts into an internal word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs share the array.
module axi_slave_mem #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int id_width   = 4,
  parameter int mem_depth  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [id_width-1:0]     awid,
  input  logic [addr_width-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [data_width-1:0]   wdata,
  input  logic [data_width/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [id_width-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [id_width-1:0]     arid,
  input  logic [addr_width-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [id_width-1:0]     rid,
  output logic [data_width-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB   = data_width / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(mem_depth);
  localparam logic [2:0] SZ = 3'(OFFW);
  localparam logic [addr_width-1:0] DEPTH = addr_width'(mem_depth);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [data_width-1:0] mem [mem_depth];

  // ---------------- write path ----------------
  wstate_t               wst_q, wst_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [id_width-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [id_width-1:0]   wid_q, wid_d;
  logic [addr_width-1:0] widx_q, widx_d;
  logic [7:0]            wlen_q, wlen_d;
  logic                  wfixed_q, wfixed_d;
  logic [8:0]            wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  mem_we, wbeat_last;

  always_comb begin
    wst_d = wst_q; awready_d = awready_q; wready_d = wready_q;
    bvalid_d = bvalid_q; bid_d = bid_q; bresp_d = bresp_q;
    wid_d = wid_q; widx_d = widx_q; wlen_d = wlen_q; wfixed_d = wfixed_q;
    wcnt_d = wcnt_q; werr_d = werr_q;
    mem_we = 1'b0;
    wbeat_last = (wcnt_q == {1'b0, wlen_q});
    case (wst_q)
      W_IDLE: if (awvalid && awready_q) begin
        wid_d     = awid;
        widx_d    = awaddr >> OFFW;
        wlen_d    = awlen;
        wfixed_d  = (awburst == 2'b00);
        wcnt_d    = '0;
        werr_d    = awburst[1] || (awsize != SZ);
        awready_d = 1'b0;
        wready_d  = 1'b1;
        wst_d     = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        if (widx_q < DEPTH) mem_we = 1'b1;
        else                werr_d = 1'b1;
        if (wlast != wbeat_last) werr_d = 1'b1;
        if (!wfixed_q) widx_d = widx_q + 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        // Burst ends on the beat count alone; a wrong wlast only flags an error.
        if (wbeat_last) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = werr_d ? 2'b10 : 2'b00;
          wst_d    = W_RESP;
        end
      end
      W_RESP: if (bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wst_d     = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q <= W_IDLE; awready_q <= 1'b1; wready_q <= 1'b0;
      bvalid_q <= 1'b0; bid_q <= '0; bresp_q <= '0;
      wid_q <= '0; widx_q <= '0; wlen_q <= '0; wfixed_q <= 1'b0;
      wcnt_q <= '0; werr_q <= 1'b0;
    end else begin
      wst_q <= wst_d; awready_q <= awready_d; wready_q <= wready_d;
      bvalid_q <= bvalid_d; bid_q <= bid_d; bresp_q <= bresp_d;
      wid_q <= wid_d; widx_q <= widx_d; wlen_q <= wlen_d; wfixed_q <= wfixed_d;
      wcnt_q <= wcnt_d; werr_q <= werr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem[widx_q[IW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  // ---------------- read path ----------------
  rstate_t               rst_q, rst_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [id_width-1:0]   rid_q, rid_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [addr_width-1:0] ridx_q, ridx_d;
  logic [7:0]            rlen_q, rlen_d;
  logic                  rfixed_q, rfixed_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  rerr_q, rerr_d;
  logic [addr_width-1:0] ld_idx;
  logic                  ld_inr, ar_err, ar_fixed;
  logic [data_width-1:0] ld_word;

  // Loads sample the array before this edge's write lands, so a same-cycle hit sees old data.
  assign ld_idx   = (rst_q == R_IDLE) ? (araddr >> OFFW) : ridx_q;
  assign ld_inr   = (ld_idx < DEPTH);
  assign ld_word  = mem[ld_idx[IW-1:0]];
  assign ar_err   = arburst[1] || (arsize != SZ);
  assign ar_fixed = (arburst == 2'b00);

  always_comb begin
    rst_d = rst_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q;
    ridx_d = ridx_q; rlen_d = rlen_q; rfixed_d = rfixed_q; rcnt_d = rcnt_q; rerr_d = rerr_q;
    case (rst_q)
      R_IDLE: if (arvalid && arready_q) begin
        rid_d     = arid;
        rlen_d    = arlen;
        rfixed_d  = ar_fixed;
        rerr_d    = ar_err;
        rcnt_d    = '0;
        rvalid_d  = 1'b1;
        rlast_d   = (arlen == 8'd0);
        rdata_d   = ld_inr ? ld_word : '0;
        rresp_d   = (!ld_inr || ar_err) ? 2'b10 : 2'b00;
        ridx_d    = ar_fixed ? ld_idx : ld_idx + 1'b1;
        arready_d = 1'b0;
        rst_d     = R_DATA;
      end
      R_DATA: if (rvalid_q && rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          rst_d     = R_IDLE;
        end else begin
          rcnt_d  = rcnt_q + 1'b1;
          rlast_d = (rcnt_d == rlen_q);
          rdata_d = ld_inr ? ld_word : '0;
          rresp_d = (!ld_inr || rerr_q) ? 2'b10 : 2'b00;
          ridx_d  = rfixed_q ? ridx_q : ridx_q + 1'b1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q <= R_IDLE; arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q <= '0; rdata_q <= '0; rresp_q <= '0;
      ridx_q <= '0; rlen_q <= '0; rfixed_q <= 1'b0; rcnt_q <= '0; rerr_q <= 1'b0;
    end else begin
      rst_q <= rst_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
      ridx_q <= ridx_d; rlen_q <= rlen_d; rfixed_q <= rfixed_d; rcnt_q <= rcnt_d; rerr_q <= rerr_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem against a word-array reference model of the AXI rules.
module tb_axi_slave_mem;
  localparam int DEPTH = 256;

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_tests = 0, n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd[$];
  logic [3:0]  ws[$];
  bit          rpat[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Beats come from wd/ws; wlast is driven only on beat wl_beat (-1 = never).
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int wl_beat, input int bdelay);
    logic [31:0] d[$];
    logic [3:0]  s[$];
    int t, idx;
    bit err;
    d = wd; s = ws;
    err = burst[1] || (size != 3'd2) || (wl_beat != len);
    for (int i = 0; i <= len; i++) begin
      idx = int'(addr >> 2) + ((burst == 2'b00) ? 0 : i);
      if (idx < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (s[i][b]) ref_mem[idx][b*8 +: 8] = d[i][b*8 +: 8];
      end else err = 1;
    end
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1;
    t = 0;
    while (!awready && t < 50) begin tick(); t++; end
    chk("awready", awready, 1);
    tick(); awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1; wdata = d[i]; wstrb = s[i]; wlast = (i == wl_beat);
      t = 0;
      while (!wready && t < 50) begin tick(); t++; end
      if (!wready) begin chk("wready", wready, 1); break; end
      tick();
    end
    wvalid = 0; wlast = 0;
    t = 0;
    while (!bvalid && t < 50) begin tick(); t++; end
    chk("bvalid", bvalid, 1);
    for (int c = 0; c < bdelay; c++) begin
      chk("bvalid_hold", bvalid, 1);
      chk("bid_hold", bid, id);
      chk("bresp_hold", bresp, err ? 2'b10 : 2'b00);
      tick();
    end
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    bready = 1; tick(); bready = 0;
    chk("bvalid_clr", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  // rready follows rpat, then random (rnd) or constant 1.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit rnd);
    logic [31:0] ed[$];
    logic [1:0]  er[$];
    bit pat[$];
    int t, idx, beat, cyc;
    bit bad, rr;
    pat = rpat;
    bad = burst[1] || (size != 3'd2);
    for (int i = 0; i <= len; i++) begin
      idx = int'(addr >> 2) + ((burst == 2'b00) ? 0 : i);
      ed.push_back((idx < DEPTH) ? ref_mem[idx] : 32'h0);
      er.push_back((idx >= DEPTH || bad) ? 2'b10 : 2'b00);
    end
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1;
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    chk("arready", arready, 1);
    tick(); arvalid = 0;
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 4000) begin
      chk("rvalid", rvalid, 1);
      if (!rvalid) break;
      chk($sformatf("rdata[%0d]", beat), rdata, ed[beat]);
      chk($sformatf("rresp[%0d]", beat), rresp, er[beat]);
      chk($sformatf("rlast[%0d]", beat), rlast, beat == len);
      chk("rid", rid, id);
      rr = (cyc < pat.size()) ? pat[cyc] : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      rready = rr;
      tick();
      if (rr) beat++;
      cyc++;
    end
    rready = 0;
    chk("rvalid_clr", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  task automatic fill(input int n, input bit rnd_data, input logic [31:0] d0, input logic [3:0] s0);
    wd.delete(); ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back(rnd_data ? $urandom : d0 + 32'(i) * 32'h11);
      ws.push_back(s0);
    end
  endtask

  initial begin
    int len, idx, wl, r;
    logic [1:0] bu;
    logic [2:0] sz;
    logic [31:0] a;
    tick();
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    tick(); rst = 0; tick();

    // Whole-array 256-beat burst so the model is fully defined.
    fill(256, 1, 0, 4'hF);
    axi_write(4'd3, 32'h0, 255, 3'd2, 2'b01, 255, 0);
    axi_read(4'd3, 32'h0, 255, 3'd2, 2'b01, 1);

    fill(4, 0, 32'h11, 4'hF);
    axi_write(4'd1, 32'h10, 3, 3'd2, 2'b01, 3, 0);
    axi_read(4'd1, 32'h10, 3, 3'd2, 2'b01, 0);

    fill(1, 0, 32'hFFFFFFFF, 4'hF);
    axi_write(4'd2, 32'h20, 0, 3'd2, 2'b01, 0, 0);
    fill(1, 0, 32'h12345678, 4'b0101);
    axi_write(4'd2, 32'h20, 0, 3'd2, 2'b01, 0, 0);
    axi_read(4'd2, 32'h20, 0, 3'd2, 2'b01, 0);
    chk("strobe_word", rdata, 32'hFF34FF78);

    fill(2, 1, 0, 4'hF);
    axi_write(4'd5, 32'h30, 1, 3'd2, 2'b01, 1, 5);
    rpat.delete(); rpat.push_back(1); rpat.push_back(0); rpat.push_back(0); rpat.push_back(1);
    axi_read(4'd6, 32'h30, 3, 3'd2, 2'b01, 0);
    rpat.delete();

    fill(2, 1, 0, 4'hF);
    axi_write(4'd7, (DEPTH - 1) * 4, 1, 3'd2, 2'b01, 1, 0);
    fill(3, 1, 0, 4'hF);
    axi_write(4'd8, 32'h40, 2, 3'd2, 2'b01, 0, 0);
    axi_read(4'd9, (DEPTH - 2) * 4, 3, 3'd2, 2'b01, 0);
    fill(2, 1, 0, 4'hF);
    axi_write(4'd10, 32'h50, 1, 3'd1, 2'b10, 1, 0);
    fill(3, 1, 0, 4'hF);
    axi_write(4'd11, 32'h60, 2, 3'd2, 2'b00, 2, 0);
    axi_read(4'd11, 32'h60, 2, 3'd2, 2'b00, 0);
    axi_read(4'd12, 32'h50, 1, 3'd2, 2'b11, 0);

    // AW and AR issued in the same cycle to different words.
    fill(2, 1, 0, 4'hF);
    fork
      axi_write(4'd4, 32'h80, 1, 3'd2, 2'b01, 1, 0);
      axi_read(4'd13, 32'h44, 0, 3'd2, 2'b01, 0);
    join

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 7);
      idx = ($urandom_range(0, 4) == 0) ? $urandom_range(DEPTH - 6, DEPTH + 2) : $urandom_range(0, DEPTH - 1);
      a = 32'(idx * 4 + $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      bu = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
      sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 7);
        wl = (r == 0) ? -1 : (r == 1) ? $urandom_range(0, len) : len;
        fill(len + 1, 1, 0, 4'hF);
        for (int i = 0; i <= len; i++) ws[i] = 4'($urandom);
        axi_write(4'($urandom), a, len, sz, bu, wl, $urandom_range(0, 3));
      end else
        axi_read(4'($urandom), a, len, sz, bu, 1);
    end

    fill(1, 0, 32'hA5A5A5A5, 4'hF);
    axi_write(4'd1, 32'h0, 0, 3'd2, 2'b01, 0, 0);
    arid = 4'd2; araddr = 32'h0; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
    tick(); arvalid = 0;
    rready = 1; tick(); rready = 0;
    chk("pre_rst_rvalid", rvalid, 1);
    #2 rst = 1; #1;
    chk("async_rvalid", rvalid, 0);
    chk("async_rlast", rlast, 0);
    chk("async_awready", awready, 1);
    chk("async_arready", arready, 1);
    tick(); tick(); rst = 0; tick();
    axi_read(4'd2, 32'h0, 0, 3'd2, 2'b01, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
